// File: rtl/sm4_pkg.sv
// Shared constants for the SM4 job controller: core opcodes, host command codes, FSM states.
package sm4_pkg;

    localparam int unsigned BLK_W = 128;

    localparam logic [1:0] OP_KEY  = 2'b00;
    localparam logic [1:0] OP_ENC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b11;
    localparam logic [1:0] OP_IDLE = 2'b10;

    localparam logic [1:0] CMD_LOAD_KEY = 2'd0;
    localparam logic [1:0] CMD_ENC      = 2'd1;
    localparam logic [1:0] CMD_DEC      = 2'd2;
    localparam logic [1:0] CMD_RSVD     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_KEY_RUN  = 2'd1,
        ST_DATA_RUN = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    // Core opcode for a host data command (encrypt or decrypt).
    function automatic logic [1:0] data_core_op(input logic [1:0] cmd);
        return (cmd == CMD_DEC) ? OP_DEC : OP_ENC;
    endfunction

endpackage

// File: rtl/sm4_watchdog.sv
// Job watchdog: counts cycles while enabled, flags expiry on the TIMEOUT_CYCLES-th cycle.
module sm4_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic top_clk,
    input  logic top_rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [TMO_W-1:0] cnt;

    // Saturates so a stalled enable can never wrap back to an unexpired count.
    always_ff @(posedge top_clk or posedge top_rst) begin
        if (top_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != TMO_W'(TIMEOUT_CYCLES))) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign expired_c = en && (cnt >= TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sm4_job_ctrl.sv
// SM4 job sequencer between a host command/response channel and the unrolled SM4 core.
// Define SM4_JOB_CTRL_PERF_EN to add the perf_blocks / perf_errors counters.
module sm4_job_ctrl
    import sm4_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             top_clk,
    input  logic             top_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [BLK_W-1:0] cmd_key,
    input  logic [BLK_W-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [BLK_W-1:0] rsp_data,
    output logic             rsp_err,
    output logic             key_valid,
`ifdef SM4_JOB_CTRL_PERF_EN
    output logic [31:0]      perf_blocks,
    output logic [15:0]      perf_errors,
`endif
    output logic [1:0]       core_opcode,
    output logic [BLK_W-1:0] core_key,
    output logic [BLK_W-1:0] core_datain,
    output logic             core_last,
    output logic             core_handshake,
    input  logic [BLK_W-1:0] core_dataout,
    input  logic             core_rk_complete,
    input  logic             core_data_complete
);

    state_e           state, state_n;
    logic             rsp_err_n, key_valid_n;
    logic [BLK_W-1:0] rsp_data_n, core_key_n, core_datain_n;
    logic [1:0]       core_opcode_n;
    logic             wd_clr, wd_en, wd_expired_c;
    logic             blk_done, err_rsp;

    sm4_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TMO_W         (TMO_W)
    ) u_watchdog (
        .top_clk  (top_clk),
        .top_rst  (top_rst),
        .clr      (wd_clr),
        .en       (wd_en),
        .expired_c(wd_expired_c)
    );

    // State and registered outputs; handshake/strobe outputs follow the next state.
    always_ff @(posedge top_clk or posedge top_rst) begin
        if (top_rst) begin
            state          <= ST_IDLE;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            key_valid      <= 1'b0;
            core_opcode    <= OP_IDLE;
            core_key       <= '0;
            core_datain    <= '0;
            core_last      <= 1'b0;
            core_handshake <= 1'b0;
        end else begin
            state          <= state_n;
            cmd_ready      <= (state_n == ST_IDLE);
            rsp_valid      <= (state_n == ST_RESP);
            rsp_data       <= rsp_data_n;
            rsp_err        <= rsp_err_n;
            key_valid      <= key_valid_n;
            core_opcode    <= core_opcode_n;
            core_key       <= core_key_n;
            core_datain    <= core_datain_n;
            core_last      <= (state_n == ST_KEY_RUN);
            core_handshake <= (state_n == ST_KEY_RUN);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state;
        rsp_data_n    = rsp_data;
        rsp_err_n     = rsp_err;
        key_valid_n   = key_valid;
        core_opcode_n = OP_IDLE;
        core_key_n    = core_key;
        core_datain_n = core_datain;
        wd_clr        = 1'b0;
        wd_en         = 1'b0;
        blk_done      = 1'b0;
        err_rsp       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_op == CMD_LOAD_KEY) begin
                        core_key_n    = cmd_key;
                        key_valid_n   = 1'b0;
                        wd_clr        = 1'b1;
                        core_opcode_n = OP_KEY;
                        state_n       = ST_KEY_RUN;
                    end else if ((cmd_op != CMD_RSVD) && key_valid) begin
                        core_datain_n = cmd_data;
                        wd_clr        = 1'b1;
                        core_opcode_n = data_core_op(cmd_op);
                        state_n       = ST_DATA_RUN;
                    end else begin
                        rsp_err_n  = 1'b1;
                        rsp_data_n = '0;
                        err_rsp    = 1'b1;
                        state_n    = ST_RESP;
                    end
                end
            end
            ST_KEY_RUN: begin
                wd_en         = 1'b1;
                core_opcode_n = OP_KEY;
                if (core_rk_complete) begin
                    key_valid_n   = 1'b1;
                    rsp_err_n     = 1'b0;
                    rsp_data_n    = '0;
                    core_opcode_n = OP_IDLE;
                    state_n       = ST_RESP;
                end else if (wd_expired_c) begin
                    rsp_err_n     = 1'b1;
                    rsp_data_n    = '0;
                    err_rsp       = 1'b1;
                    core_opcode_n = OP_IDLE;
                    state_n       = ST_RESP;
                end
            end
            ST_DATA_RUN: begin
                wd_en         = 1'b1;
                core_opcode_n = core_opcode;
                // Completion is tested first so it wins over a same-cycle timeout.
                if (core_data_complete) begin
                    rsp_data_n    = core_dataout;
                    rsp_err_n     = 1'b0;
                    blk_done      = 1'b1;
                    core_opcode_n = OP_IDLE;
                    state_n       = ST_RESP;
                end else if (wd_expired_c) begin
                    rsp_err_n     = 1'b1;
                    rsp_data_n    = '0;
                    err_rsp       = 1'b1;
                    core_opcode_n = OP_IDLE;
                    state_n       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

`ifdef SM4_JOB_CTRL_PERF_EN
    // Saturating job statistics.
    always_ff @(posedge top_clk or posedge top_rst) begin
        if (top_rst) begin
            perf_blocks <= '0;
            perf_errors <= '0;
        end else begin
            if (blk_done && (perf_blocks != '1)) begin
                perf_blocks <= perf_blocks + 32'd1;
            end
            if (err_rsp && (perf_errors != '1)) begin
                perf_errors <= perf_errors + 16'd1;
            end
        end
    end
`else
    logic perf_unused;
    assign perf_unused = blk_done ^ err_rsp;
`endif

endmodule
